raw_hazard_scoreboard: RTL and testbench
========================================

// Module: raw_hazard_scoreboard
// PURPOSE
// - Read-after-write hazard detector that feeds reg_fetch_freeze_in of the control unit.
// - Tracks destination registers of in-flight instructions, from EX through write-back,
//   in a PIPE_DEPTH-entry shift register.
// - Compares them against the sources of the instruction now in register fetch and
//   raises reg_fetch_freeze_out until the conflicting producer retires.
// - Squashes wrong-path entries on a taken branch.
// PARAMETERS
// - REG_ADDR_W  5  width of a GPR address; R0 is hardwired and never hazards
// - PIPE_DEPTH  3  tracked stages after register fetch (EX, MEM, WB); entry PIPE_DEPTH-1 is oldest
// - FLUSH_DEPTH 2  youngest entries invalidated on branch_taken_in
// PORTS
// - clock              in   1           single clock; all state updates on posedge
// - reset_n            in   1           asynchronous, active-low reset
// - enable_in          in   1           pipeline run; low = hold all state
// - read_data_1_in     in   1           fetch-stage instr uses src1
// - read_data_2_in     in   1           fetch-stage instr uses src2
// - src1_addr_in       in   REG_ADDR_W  source register 1 address
// - src2_addr_in       in   REG_ADDR_W  source register 2 address
// - read_special_in    in   1           instr reads HI/LO (mfhi/mflo)
// - write_back_in      in   1           instr writes GPR dest_addr_in
// - write_special_in   in   1           instr writes HI/LO
// - dest_addr_in       in   REG_ADDR_W  destination register address
// - branch_taken_in    in   1           taken branch resolved this cycle
// - reg_fetch_freeze_out out 1          RAW hazard present; hold fetch/decode
// - stall_count_out    out  16          stalled-cycle count (STALL_COUNT_EN only)
// BEHAVIOUR
// - Entry format: {valid, wr_gpr, wr_spec, dest[REG_ADDR_W-1:0]}.
// - Reset (async, reset_n=0): all entries cleared to 0.
//   reg_fetch_freeze_out=0 and stall_count_out=0 while reset is asserted.
// - Hazard (combinational, same-cycle):
//   - src1 hazard = read_data_1_in && src1!=0 && any entry valid&wr_gpr&dest==src1.
//   - src2 hazard is the same check against src2.
//   - Special hazard = read_special_in && any entry valid&wr_spec.
//   - reg_fetch_freeze_out = enable_in && (src1 | src2 | special hazard) && !branch_taken_in.
// - Shift, each posedge with enable_in=1:
//   - entry[i] <= entry[i-1] for i>=1.
//   - entry[0] <= incoming instr {1, write_back_in, write_special_in, dest_addr_in}
//     when freeze is 0; otherwise a bubble (all 0).
//   - The oldest entry drops out.
//   - A stall therefore lasts at most PIPE_DEPTH cycles. Back-to-back dependent pair
//     = PIPE_DEPTH stall cycles.
// - Writer with dest_addr_in==0 and wr_spec=0: stored with wr_gpr forced 0.
// - Branch flush (branch_taken_in=1 at posedge, enable_in=1):
//   - Entries 0..FLUSH_DEPTH-1, after the shift, get valid=0.
//   - The incoming instr is inserted as a bubble.
//   - Older entries shift normally.
//   - Flush has priority over freeze.
// - enable_in=0: entries hold, no shift, freeze forced 0. Resume restarts from held state.
// - Async reset mid-stall clears entries immediately; freeze drops in the same cycle.
// - Simultaneous src1 and src2 hazard on different producers:
//   freeze holds until the younger producer leaves.
// CONFIGURATION
// - STALL_COUNT_EN defined:
//   - 16-bit counter increments on each posedge where reg_fetch_freeze_out=1.
//   - Saturates at 16'hFFFF.
//   - Cleared only by reset; output = counter.
// - Undefined: no counter flops; stall_count_out tied to 16'h0000.
// TESTING
// - Reset: reset_n=0 mid-run -> freeze=0, all entries invalid, stall_count=0.
// - addi r3 (wb=1,dest=3) then add r5,r3,r4 (src1=3) -> freeze high 3 cycles, low on 4th.
//   stall_count=3 with STALL_COUNT_EN.
// - lw r7 then 1 unrelated instr then use r7 -> freeze high exactly 2 cycles.
// - Dest r0 producer then src1=0 consumer -> freeze never asserts.
// - mtlo (wr_spec=1) then mflo (read_special=1) -> freeze high 3 cycles.
// - Producer r9, branch_taken_in at next posedge, then consumer r9 -> no freeze.
//   Entry flushed.
// - Stall active, enable_in=0 for 5 cycles -> freeze=0, entries unchanged.
//   Re-enable -> freeze resumes for remaining cycles.

Source files
------------

// File: rtl/raw_hazard_scoreboard.sv
// raw_hazard_scoreboard
//   Read-after-write hazard detector for the register-fetch stage. Keeps the
//   destinations of the instructions in flight (EX, MEM, WB) in a shift
//   register and freezes fetch/decode while the instruction in register fetch
//   reads a register, or HI/LO, that one of them has yet to write back.
//   Entry 0 is the youngest tracked instruction (EX); entry PIPE_DEPTH-1 is the
//   oldest (WB).
//
// Optional feature: define STALL_COUNT_EN to build a saturating 16-bit count
//   of frozen cycles. Without it, stall_count_out is tied to zero and no
//   counter flops exist.
//
// Ports
//   clock                 in   single clock, all state changes on posedge
//   reset_n               in   asynchronous active-low reset
//   enable_in             in   pipeline run; low holds all state
//   read_data_1_in        in   fetch-stage instruction reads src1
//   read_data_2_in        in   fetch-stage instruction reads src2
//   src1_addr_in          in   source register 1 address
//   src2_addr_in          in   source register 2 address
//   read_special_in       in   instruction reads HI/LO
//   write_back_in         in   instruction writes GPR dest_addr_in
//   write_special_in      in   instruction writes HI/LO
//   dest_addr_in          in   destination register address
//   branch_taken_in       in   taken branch resolved this cycle
//   reg_fetch_freeze_out  out  RAW hazard present; hold fetch/decode
//   stall_count_out       out  frozen-cycle count (zero unless STALL_COUNT_EN)

module raw_hazard_scoreboard #(
  parameter int REG_ADDR_W  = 5,
  parameter int PIPE_DEPTH  = 3,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable_in,
  input  logic                  read_data_1_in,
  input  logic                  read_data_2_in,
  input  logic [REG_ADDR_W-1:0] src1_addr_in,
  input  logic [REG_ADDR_W-1:0] src2_addr_in,
  input  logic                  read_special_in,
  input  logic                  write_back_in,
  input  logic                  write_special_in,
  input  logic [REG_ADDR_W-1:0] dest_addr_in,
  input  logic                  branch_taken_in,
  output logic                  reg_fetch_freeze_out,
  output logic [15:0]           stall_count_out
);

  typedef struct packed {
    logic                  valid;
    logic                  wr_gpr;
    logic                  wr_spec;
    logic [REG_ADDR_W-1:0] dest;
  } entry_t;

  entry_t r_entry [PIPE_DEPTH];
  entry_t w_next  [PIPE_DEPTH];
  entry_t w_incoming;

  logic w_src1_hit;
  logic w_src2_hit;
  logic w_spec_hit;
  logic w_freeze;

  // R0 is hardwired, so a GPR write to it is recorded as no GPR write at all.
  always_comb begin
    w_incoming         = '0;
    w_incoming.valid   = 1'b1;
    w_incoming.wr_gpr  = write_back_in &&
                         !((dest_addr_in == '0) && !write_special_in);
    w_incoming.wr_spec = write_special_in;
    w_incoming.dest    = dest_addr_in;
  end

  always_comb begin
    w_src1_hit = 1'b0;
    w_src2_hit = 1'b0;
    w_spec_hit = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (r_entry[i].valid && r_entry[i].wr_gpr && (r_entry[i].dest == src1_addr_in))
        w_src1_hit = 1'b1;
      if (r_entry[i].valid && r_entry[i].wr_gpr && (r_entry[i].dest == src2_addr_in))
        w_src2_hit = 1'b1;
      if (r_entry[i].valid && r_entry[i].wr_spec)
        w_spec_hit = 1'b1;
    end
  end

  // A taken branch kills the fetch-stage instruction, so it cannot stall.
  always_comb begin
    w_freeze = enable_in && !branch_taken_in &&
               ((read_data_1_in && (src1_addr_in != '0) && w_src1_hit) ||
                (read_data_2_in && (src2_addr_in != '0) && w_src2_hit) ||
                (read_special_in && w_spec_hit));
  end

  assign reg_fetch_freeze_out = w_freeze;

  // Next contents on an enabled edge: shift one place toward the oldest slot,
  // insert the fetch-stage instruction (or a bubble), then invalidate the
  // wrong-path slots on a taken branch.
  always_comb begin
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      w_next[i] = '0;
    end
    w_next[0] = (w_freeze || branch_taken_in) ? '0 : w_incoming;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      w_next[i] = r_entry[i-1];
      if (branch_taken_in && (i < FLUSH_DEPTH))
        w_next[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_entry[i] <= '0;
      end
    end else if (enable_in) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_entry[i] <= w_next[i];
      end
    end
  end

`ifdef STALL_COUNT_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_count <= '0;
    end else if (w_freeze && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count_out = r_stall_count;
`else
  assign stall_count_out = 16'h0000;
`endif

endmodule

// File: tb/tb_raw_hazard_scoreboard.sv
module tb_raw_hazard_scoreboard;

  logic        clock;
  logic        reset_n;
  logic        enable_in;
  logic        read_data_1_in;
  logic        read_data_2_in;
  logic [4:0]  src1_addr_in;
  logic [4:0]  src2_addr_in;
  logic        read_special_in;
  logic        write_back_in;
  logic        write_special_in;
  logic [4:0]  dest_addr_in;
  logic        branch_taken_in;
  logic        reg_fetch_freeze_out;
  logic [15:0] stall_count_out;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_cnt = '0;

  raw_hazard_scoreboard #(
    .REG_ADDR_W (5),
    .PIPE_DEPTH (3),
    .FLUSH_DEPTH(2)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .enable_in           (enable_in),
    .read_data_1_in      (read_data_1_in),
    .read_data_2_in      (read_data_2_in),
    .src1_addr_in        (src1_addr_in),
    .src2_addr_in        (src2_addr_in),
    .read_special_in     (read_special_in),
    .write_back_in       (write_back_in),
    .write_special_in    (write_special_in),
    .dest_addr_in        (dest_addr_in),
    .branch_taken_in     (branch_taken_in),
    .reg_fetch_freeze_out(reg_fetch_freeze_out),
    .stall_count_out     (stall_count_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk1(input logic obs, input logic exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt_expect();
`ifdef STALL_COUNT_EN
    return exp_cnt;
`else
    return 16'h0000;
`endif
  endfunction

  // Drive one fetch-stage cycle at the falling edge, check the combinational
  // freeze and the count accumulated so far, then let the rising edge happen.
  task automatic step(input logic en, input logic rd1, input logic rd2,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic rs, input logic wb, input logic ws,
                      input logic [4:0] d, input logic br,
                      input logic exp_fz, input string tag);
    @(negedge clock);
    enable_in        = en;
    read_data_1_in   = rd1;
    read_data_2_in   = rd2;
    src1_addr_in     = s1;
    src2_addr_in     = s2;
    read_special_in  = rs;
    write_back_in    = wb;
    write_special_in = ws;
    dest_addr_in     = d;
    branch_taken_in  = br;
    #1;
    chk1(reg_fetch_freeze_out, exp_fz, tag);
    chk16(stall_count_out, cnt_expect(), {tag, "_cnt"});
    if (exp_fz) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic idle3();
    for (int k = 0; k < 3; k++) step(1,0,0,0,0,0,0,0,0,0,0,"idle");
  endtask

  initial begin
    reset_n = 1'b0;
    enable_in = 1'b0; read_data_1_in = 1'b0; read_data_2_in = 1'b0;
    src1_addr_in = '0; src2_addr_in = '0; read_special_in = 1'b0;
    write_back_in = 1'b0; write_special_in = 1'b0; dest_addr_in = '0;
    branch_taken_in = 1'b0;
    #2;
    chk1(reg_fetch_freeze_out, 1'b0, "reset_freeze");
    chk16(stall_count_out, 16'h0, "reset_cnt");
    @(negedge clock);
    reset_n = 1'b1;
    idle3();

    // addi r3 ; add r5,r3,r4 -> three frozen cycles
    step(1,0,0,0,0,0,1,0,3,0,0,"t1_prod");
    step(1,1,1,3,4,0,1,0,5,0,1,"t1_a");
    step(1,1,1,3,4,0,1,0,5,0,1,"t1_b");
    step(1,1,1,3,4,0,1,0,5,0,1,"t1_c");
    step(1,1,1,3,4,0,1,0,5,0,0,"t1_go");
    idle3();

    // lw r7 ; unrelated ; use r7 -> two frozen cycles
    step(1,0,0,0,0,0,1,0,7,0,0,"t2_prod");
    step(1,1,0,2,0,0,1,0,8,0,0,"t2_mid");
    step(1,1,0,7,0,0,0,0,0,0,1,"t2_a");
    step(1,1,0,7,0,0,0,0,0,0,1,"t2_b");
    step(1,1,0,7,0,0,0,0,0,0,0,"t2_go");
    idle3();

    // r0 producer and r0 consumer never hazard
    step(1,0,0,0,0,0,1,0,0,0,0,"t3_prod");
    step(1,1,1,0,0,0,0,0,0,0,0,"t3_use");
    idle3();

    // mtlo ; mflo -> three frozen cycles
    step(1,0,0,0,0,0,0,1,0,0,0,"t4_mtlo");
    step(1,0,0,0,0,1,0,0,0,0,1,"t4_a");
    step(1,0,0,0,0,1,0,0,0,0,1,"t4_b");
    step(1,0,0,0,0,1,0,0,0,0,1,"t4_c");
    step(1,0,0,0,0,1,0,0,0,0,0,"t4_go");
    idle3();

    // producer r9 flushed by a taken branch; freeze masked in the branch cycle
    step(1,0,0,0,0,0,1,0,9,0,0,"t5_prod");
    step(1,1,0,9,0,0,0,0,0,1,0,"t5_br");
    step(1,1,0,9,0,0,0,0,0,0,0,"t5_use");
    idle3();

    // producer two slots older than the branch survives the flush
    step(1,0,0,0,0,0,1,0,10,0,0,"t5b_prod");
    step(1,0,0,0,0,0,0,0,0,0,0,"t5b_gap");
    step(1,0,0,0,0,0,0,0,0,1,0,"t5b_br");
    step(1,1,0,10,0,0,0,0,0,0,1,"t5b_old");
    step(1,1,0,10,0,0,0,0,0,0,0,"t5b_go");
    idle3();

    // stall interrupted by five disabled cycles, then resumes
    step(1,0,0,0,0,0,1,0,3,0,0,"t6_prod");
    step(1,1,0,3,0,0,0,0,0,0,1,"t6_a");
    for (int k = 0; k < 5; k++) step(0,1,0,3,0,0,0,0,0,0,0,"t6_hold");
    step(1,1,0,3,0,0,0,0,0,0,1,"t6_b");
    step(1,1,0,3,0,0,0,0,0,0,1,"t6_c");
    step(1,1,0,3,0,0,0,0,0,0,0,"t6_go");
    idle3();

    // src1 and src2 on different producers: held until the younger leaves
    step(1,0,0,0,0,0,1,0,3,0,0,"t7_p3");
    step(1,0,0,0,0,0,1,0,4,0,0,"t7_p4");
    step(1,1,1,3,4,0,0,0,0,0,1,"t7_a");
    step(1,1,1,3,4,0,0,0,0,0,1,"t7_b");
    step(1,1,1,3,4,0,0,0,0,0,1,"t7_c");
    step(1,1,1,3,4,0,0,0,0,0,0,"t7_go");
    idle3();

    // src2-only hazard
    step(1,0,0,0,0,0,1,0,12,0,0,"t7s2_prod");
    step(1,0,1,0,12,0,0,0,0,0,1,"t7s2_a");
    step(1,0,1,0,12,0,0,0,0,0,1,"t7s2_b");
    step(1,0,1,0,12,0,0,0,0,0,1,"t7s2_c");
    step(1,0,1,0,12,0,0,0,0,0,0,"t7s2_go");
    idle3();

    // matching address but no read enable, and matching address with no write
    step(1,0,0,0,0,0,1,0,6,0,0,"t8_prod");
    step(1,0,0,6,6,0,0,0,0,0,0,"t8_nord");
    idle3();
    step(1,0,0,0,0,0,0,0,11,0,0,"t8_nowb_prod");
    step(1,1,0,11,0,0,0,0,0,0,0,"t8_nowb");
    idle3();

    // asynchronous reset in the middle of a stall
    step(1,0,0,0,0,0,1,0,3,0,0,"t9_prod");
    step(1,1,0,3,0,0,0,0,0,0,1,"t9_a");
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk1(reg_fetch_freeze_out, 1'b0, "t9_rst_freeze");
    chk16(stall_count_out, 16'h0, "t9_rst_cnt");
    exp_cnt = '0;
    @(negedge clock);
    reset_n = 1'b1;
    step(1,1,0,3,0,0,0,0,0,0,0,"t9_after");
    idle3();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
